// File: rtl/btpipe_pkg.sv
// -----------------------------------------------------------------------------
// btpipe_pkg
// Shared definitions for the block-throttled pipe-in receive path:
//   - blk_state_t      : block framing FSM states (IDLE, RECV)
//   - DEF_DATA_W       : default word width (pipe endpoint width)
//   - DEF_BLOCK_WORDS  : default host block size in words
//   - EP_ADDR_PIPE_IN  : okBTPipeIn endpoint address used at the top level
// -----------------------------------------------------------------------------
package btpipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } blk_state_t;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_BLOCK_WORDS = 16;

  localparam logic [7:0] EP_ADDR_PIPE_IN = 8'h80;

endpackage

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// Circular word buffer with count register, single clock.
// Ports:
//   clock, reset   : clock, asynchronous active-low reset (control only)
//   flush          : synchronous clear of pointers and count; same-cycle
//                    push/pop are ignored
//   wr_en, wr_data : write request and word; accepted when not full or when a
//                    pop happens in the same cycle
//   rd_en          : consumer ready; pops the head when rd_valid is high
//   rd_data        : head word (combinational from the array, 0 when empty)
//   rd_valid       : buffer not empty
//   count          : words held
//   next_count     : count after the current edge (used for throttling)
//   wr_drop        : a write was refused because the buffer was full
// -----------------------------------------------------------------------------
module sync_fifo_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   next_count,
  output logic                     wr_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              push;
  logic              pop;

  assign full     = (count == CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_en && rd_valid && !flush;
  // A pop in the same cycle frees the slot the incoming word needs.
  assign push     = wr_en && (!full || pop) && !flush;
  assign wr_drop  = wr_en && full && !pop && !flush;

  always_comb begin
    next_count = count;
    if (flush) begin
      next_count = '0;
    end else if (push && !pop) begin
      next_count = count + CW'(1);
    end else if (pop && !push) begin
      next_count = count - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= next_count;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage carries no reset; the output gate below hides stale contents.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/btpipe_in_buffer.sv
// -----------------------------------------------------------------------------
// btpipe_in_buffer
// Host-to-device receive buffer for an okBTPipeIn endpoint. Accepts host words
// in fixed-size blocks, throttles the host so a started block always fits,
// and presents words to a consumer over a valid/ready stream.
// Ports:
//   clock, reset            : ti_clk, asynchronous active-low reset
//   ep_write, ep_blockstrobe, ep_dataout : endpoint write strobe, block start,
//                             data word
//   ep_ready                : registered; room for one full block after the
//                             words still owed by the current block
//   flush                   : clears buffer and block FSM (flags/count held)
//   clear_err               : clears sticky flags (a new error wins)
//   out_data, out_valid, out_ready : consumer stream
//   fill_count              : words held
//   block_count             : completed blocks, wraps modulo 2^16
//   overflow                : sticky, a write was dropped at full
//   proto_err               : sticky, short block or write outside a block
// -----------------------------------------------------------------------------
module btpipe_in_buffer
  import btpipe_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 64,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ep_write,
  input  logic                   ep_blockstrobe,
  input  logic [DATA_W-1:0]      ep_dataout,
  output logic                   ep_ready,
  input  logic                   flush,
  input  logic                   clear_err,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fill_count,
  output logic [15:0]            block_count,
  output logic                   overflow,
  output logic                   proto_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(BLOCK_WORDS + 1);

  blk_state_t    state;
  blk_state_t    state_nxt;
  logic [IW-1:0] word_idx;
  logic [IW-1:0] idx_nxt;
  logic [IW-1:0] base_idx;
  logic [IW-1:0] pend_nxt;
  logic          blk_done;
  logic          proto_hit;
  logic          ready_nxt;
  logic [CW-1:0] next_count;
  logic          wr_drop;

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .wr_en      (ep_write),
    .wr_data    (ep_dataout),
    .rd_en      (out_ready),
    .rd_data    (out_data),
    .rd_valid   (out_valid),
    .count      (fill_count),
    .next_count (next_count),
    .wr_drop    (wr_drop)
  );

  // Block framing. A strobe restarts the index before a same-cycle write is
  // counted, so strobe+write makes that write word 0 of the new block.
  always_comb begin
    state_nxt = state;
    idx_nxt   = word_idx;
    base_idx  = word_idx;
    blk_done  = 1'b0;
    proto_hit = 1'b0;

    if (ep_blockstrobe) begin
      // In RECV the block is necessarily incomplete (completion leaves RECV).
      if (state == RECV) proto_hit = 1'b1;
      state_nxt = RECV;
      idx_nxt   = '0;
      base_idx  = '0;
    end else if ((state == IDLE) && ep_write) begin
      proto_hit = 1'b1;
    end

    if (ep_write && (ep_blockstrobe || (state == RECV))) begin
      if (base_idx == IW'(BLOCK_WORDS - 1)) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        blk_done  = 1'b1;
      end else begin
        state_nxt = RECV;
        idx_nxt   = base_idx + IW'(1);
      end
    end

    if (flush) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      blk_done  = 1'b0;
      proto_hit = 1'b0;
    end
  end

  // Words still owed by the open block are reserved before offering a new one.
  // Written as a sum so stray writes beyond the reservation cannot underflow.
  assign pend_nxt  = (state_nxt == RECV) ? (IW'(BLOCK_WORDS) - idx_nxt) : '0;
  assign ready_nxt = (32'(next_count) + 32'(pend_nxt) + 32'(BLOCK_WORDS)) <= 32'(DEPTH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      word_idx    <= '0;
      ep_ready    <= 1'b0;
      block_count <= '0;
      overflow    <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      word_idx <= idx_nxt;
      ep_ready <= ready_nxt;
      if (blk_done) block_count <= block_count + 16'd1;

      if (wr_drop)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;

      if (proto_hit)      proto_err <= 1'b1;
      else if (clear_err) proto_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btpipe_in_buffer.sv
module tb_btpipe_in_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int BW    = 16;

  logic          clk;
  logic          rst_n;
  logic          stb, wr, fl, clr, ordy;
  logic [DW-1:0] din;
  logic          ep_ready, out_valid, overflow, proto_err;
  logic [DW-1:0] out_data;
  logic [6:0]    fill_count;
  logic [15:0]   block_count;

  // Second instance, one-word blocks, used for the block counter wrap.
  logic          rst2_n, stb2, wr2;
  logic [DW-1:0] din2;
  logic          rdy2, val2, ovf2, perr2;
  logic [DW-1:0] dout2;
  logic [2:0]    fill2;
  logic [15:0]   bc2;

  int n_checks = 0;
  int n_fail   = 0;

  btpipe_in_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .BLOCK_WORDS(BW)) dut (
    .clock(clk), .reset(rst_n), .ep_write(wr), .ep_blockstrobe(stb),
    .ep_dataout(din), .ep_ready(ep_ready), .flush(fl), .clear_err(clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(ordy),
    .fill_count(fill_count), .block_count(block_count),
    .overflow(overflow), .proto_err(proto_err)
  );

  btpipe_in_buffer #(.DATA_W(DW), .DEPTH(4), .BLOCK_WORDS(1)) dut_wrap (
    .clock(clk), .reset(rst2_n), .ep_write(wr2), .ep_blockstrobe(stb2),
    .ep_dataout(din2), .ep_ready(rdy2), .flush(1'b0), .clear_err(1'b0),
    .out_data(dout2), .out_valid(val2), .out_ready(1'b1),
    .fill_count(fill2), .block_count(bc2),
    .overflow(ovf2), .proto_err(perr2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [DW-1:0] mq[$];
  bit m_in_blk;
  int m_got;       // words received in the open block
  int m_bc;
  bit m_ovf, m_perr, m_ready;

  function automatic void model_reset();
    mq.delete();
    m_in_blk = 0; m_got = 0; m_bc = 0;
    m_ovf = 0; m_perr = 0; m_ready = 0;
  endfunction

  function automatic void model_update(input bit s, input bit w, input logic [DW-1:0] d,
                                       input bit o, input bit f, input bit c);
    bit err, drop, pop;
    int owed;
    err = 0; drop = 0;
    if (f) begin
      mq.delete();
      m_in_blk = 0;
      m_got = 0;
    end else begin
      pop = o && (mq.size() > 0);
      if (s) begin
        if (m_in_blk) err = 1;
        m_in_blk = 1;
        m_got = 0;
      end else if (!m_in_blk && w) begin
        err = 1;
      end
      if (w && m_in_blk) begin
        m_got++;
        if (m_got == BW) begin
          m_in_blk = 0;
          m_got = 0;
          m_bc = (m_bc + 1) % 65536;
        end
      end
      if (pop) void'(mq.pop_front());
      if (w) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else drop = 1;
      end
    end
    if (drop) m_ovf = 1; else if (c) m_ovf = 0;
    if (err) m_perr = 1; else if (c) m_perr = 0;
    owed = m_in_blk ? (BW - m_got) : 0;
    m_ready = (DEPTH - mq.size() - owed) >= BW;
  endfunction

  function automatic void compare_model();
    check("fill", 32'(fill_count), mq.size());
    check("valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check("data", 32'(out_data), 32'(mq[0]));
    check("ready", 32'(ep_ready), 32'(m_ready));
    check("blocks", 32'(block_count), m_bc);
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("proto_err", 32'(proto_err), 32'(m_perr));
  endfunction

  task automatic step(input bit s, input bit w, input logic [DW-1:0] d,
                      input bit o, input bit f, input bit c);
    @(negedge clk);
    stb = s; wr = w; din = d; ordy = o; fl = f; clr = c;
    @(posedge clk);
    model_update(s, w, d, o, f, c);
    #1;
    compare_model();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    stb = 0; wr = 0; din = '0; ordy = 0; fl = 0; clr = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(ep_ready), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_fill", 32'(fill_count), 0);
    check("rst_blocks", 32'(block_count), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_proto", 32'(proto_err), 0);
    check("rst_data", 32'(out_data), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit s, w;
    logic [DW-1:0] d;
    bit o, f, c;
    int e_fill;
    bit e_ready;
    int e_bc;
    bit e_perr;
  } vec_t;

  vec_t vt[12];

  task automatic main_test();
    // table: protocol errors, clear, flush, stray write, strobe+write
    vt[0] = '{1, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 0};
    for (int k = 1; k <= 5; k++)
      vt[k] = '{0, 1, 16'(16'h00A0 + k - 1), 0, 0, 0, k, 1, 0, 0};
    vt[6]  = '{1, 0, 16'h0000, 0, 0, 0, 5, 1, 0, 1};
    vt[7]  = '{0, 0, 16'h0000, 0, 0, 1, 5, 1, 0, 0};
    vt[8]  = '{0, 0, 16'h0000, 0, 1, 0, 0, 1, 0, 0};
    vt[9]  = '{0, 1, 16'h0055, 0, 0, 0, 1, 1, 0, 1};
    vt[10] = '{0, 0, 16'h0000, 1, 0, 1, 0, 1, 0, 0};
    vt[11] = '{1, 1, 16'h0010, 0, 0, 0, 1, 1, 0, 0};

    apply_reset();
    step(0, 0, 0, 0, 0, 0);
    check("ready_after_reset", 32'(ep_ready), 1);
    for (int i = 0; i < 12; i++) begin
      step(vt[i].s, vt[i].w, vt[i].d, vt[i].o, vt[i].f, vt[i].c);
      check($sformatf("vec%0d_fill", i), 32'(fill_count), vt[i].e_fill);
      check($sformatf("vec%0d_ready", i), 32'(ep_ready), 32'(vt[i].e_ready));
      check($sformatf("vec%0d_blocks", i), 32'(block_count), vt[i].e_bc);
      check($sformatf("vec%0d_proto", i), 32'(proto_err), 32'(vt[i].e_perr));
    end

    // single block, then drain in order
    apply_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < BW; i++) step(0, 1, 16'(i), 0, 0, 0);
    check("blk_fill", 32'(fill_count), 16);
    check("blk_count", 32'(block_count), 1);
    check("blk_ready", 32'(ep_ready), 1);
    for (int i = 0; i < BW; i++) begin
      check("drain_word", 32'(out_data), i);
      step(0, 0, 0, 1, 0, 0);
    end
    check("drain_empty", 32'(out_valid), 0);

    // throttle: ready holds while one full block of room remains
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      step(1, 0, 0, 0, 0, 0);
      check("thr_after_strobe", 32'(ep_ready), 32'(b < 3));
      for (int i = 0; i < BW; i++) step(0, 1, 16'(16'h1000 + b * BW + i), 0, 0, 0);
    end
    check("thr_fill", 32'(fill_count), 64);
    check("thr_ready_full", 32'(ep_ready), 0);
    check("thr_no_ovf", 32'(overflow), 0);
    check("thr_blocks", 32'(block_count), 4);

    // overflow at full, then pop+write at full
    step(0, 1, 16'hDEAD, 0, 0, 0);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_fill", 32'(fill_count), 64);
    check("ovf_head", 32'(out_data), 32'h1000);
    step(0, 0, 0, 0, 0, 1);
    check("ovf_cleared", 32'(overflow), 0);
    step(0, 1, 16'hBEEF, 1, 0, 0);
    check("popwr_fill", 32'(fill_count), 64);
    check("popwr_no_ovf", 32'(overflow), 0);
    check("popwr_head", 32'(out_data), 32'h1001);

    // flush mid-block
    apply_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 16'(i), 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check("flush_fill", 32'(fill_count), 0);
    check("flush_valid", 32'(out_valid), 0);
    check("flush_ready", 32'(ep_ready), 1);
    step(1, 0, 0, 0, 0, 0);
    check("flush_idle", 32'(proto_err), 0);

    // async reset mid-block
    for (int i = 0; i < 8; i++) step(0, 1, 16'(i), 0, 0, 0);
    apply_reset();
    step(0, 0, 0, 0, 0, 0);
    check("rst_mid_ready", 32'(ep_ready), 1);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1, 16'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 19) == 0);
    end
  endtask

  task automatic wrap_test();
    @(negedge clk);
    stb2 = 0; wr2 = 0; din2 = '0;
    #2 rst2_n = 1'b0;
    #1;
    check("wrap_rst_blocks", 32'(bc2), 0);
    @(negedge clk);
    rst2_n = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      stb2 = 1; wr2 = 1; din2 = i[15:0];
      @(posedge clk);
      #1;
      if (i == 0) check("wrap_first", 32'(bc2), 1);
      if (i == 65534) check("wrap_pre", 32'(bc2), 32'hFFFF);
    end
    @(negedge clk);
    stb2 = 0; wr2 = 0;
    check("wrap_zero", 32'(bc2), 0);
    check("wrap_no_ovf", 32'(ovf2), 0);
    check("wrap_no_proto", 32'(perr2), 0);
  endtask

  initial begin
    rst_n = 1'b1; rst2_n = 1'b1;
    stb = 0; wr = 0; din = '0; ordy = 0; fl = 0; clr = 0;
    stb2 = 0; wr2 = 0; din2 = '0;
    model_reset();
    fork
      main_test();
      wrap_test();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
